data_memory_handler: RTL and testbench

- Memory-access stage between the ALU and writeback. Turns load/store requests into single transactions on a request/acknowledge data bus.
- Aligns load data so writeback's zero-extended byte load reads from bits [7:0].
- Produces memory_value for writeback, plus a stall to freeze the core while a bus transaction is outstanding.

---
 rtl/data_memory_handler.sv | 106 ++++++++++
 tb/tb_data_memory_handler.sv | 228 ++++++++++++++++++++++
 2 files changed

// File: rtl/data_memory_handler.sv
// Memory-access stage: converts load/store requests into single request/acknowledge
// bus transactions, aligns byte-load data into bits [7:0] and stalls the core meanwhile.
module data_memory_handler #(
    parameter int TIMEOUT_CYCLES = 16
) (
    input  logic        clk,
    input  logic        nRst,
    input  logic        mem_read,
    input  logic        mem_write,
    input  logic        byte_access,
    input  logic [31:0] address,
    input  logic [31:0] store_data,
    input  logic        bus_ack,
    input  logic [31:0] bus_rdata,
    output logic [31:0] bus_addr,
    output logic [31:0] bus_wdata,
    output logic [3:0]  bus_sel,
    output logic        bus_read,
    output logic        bus_write,
    output logic [31:0] memory_value,
    output logic        mem_busy,
    output logic        misaligned,
    output logic        bus_timeout
);

    localparam int CNT_W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
    localparam logic [CNT_W-1:0] LAST_COUNT = CNT_W'(TIMEOUT_CYCLES - 1);

    typedef enum logic [1:0] {IDLE, REQ, DONE} state_t;

    state_t           state;
    logic [CNT_W-1:0] count;
    logic [1:0]       offset;
    logic             req;

    assign req = mem_read | mem_write;

    // Gated by nRst so the stall also drops the instant reset is asserted.
    assign mem_busy = nRst & (((state == IDLE) & req) | (state == REQ));

    always_ff @(posedge clk or negedge nRst) begin
        if (!nRst) begin
            state        <= IDLE;
            count        <= '0;
            offset       <= 2'd0;
            bus_addr     <= 32'd0;
            bus_wdata    <= 32'd0;
            bus_sel      <= 4'd0;
            bus_read     <= 1'b0;
            bus_write    <= 1'b0;
            memory_value <= 32'd0;
            misaligned   <= 1'b0;
            bus_timeout  <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (req) begin
                        if (!byte_access && (address[1:0] != 2'b00)) begin
                            misaligned <= 1'b1;
                            state      <= DONE;
                        end else begin
                            bus_addr  <= {address[31:2], 2'b00};
                            bus_wdata <= byte_access ? {4{store_data[7:0]}} : store_data;
                            bus_sel   <= byte_access ? (4'b0001 << address[1:0]) : 4'b1111;
                            offset    <= byte_access ? address[1:0] : 2'd0;
                            // A simultaneous read and write is treated as a store.
                            bus_write <= mem_write;
                            bus_read  <= ~mem_write;
                            count     <= '0;
                            state     <= REQ;
                        end
                    end
                end
                REQ: begin
                    if (bus_ack) begin
                        if (bus_read) begin
                            memory_value <= bus_rdata >> {offset, 3'b000};
                        end
                        bus_read  <= 1'b0;
                        bus_write <= 1'b0;
                        state     <= DONE;
                    end else if (count == LAST_COUNT) begin
                        if (bus_read) begin
                            memory_value <= 32'd0;
                        end
                        bus_read    <= 1'b0;
                        bus_write   <= 1'b0;
                        bus_timeout <= 1'b1;
                        state       <= DONE;
                    end else begin
                        count <= count + 1'b1;
                    end
                end
                DONE: begin
                    misaligned  <= 1'b0;
                    bus_timeout <= 1'b0;
                    state       <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_data_memory_handler.sv
// Bench for data_memory_handler: directed vector table, randomized transactions
// against a transaction-level model, and an asynchronous reset during a pending load.
module tb_data_memory_handler;

    localparam int T = 4;

    logic        clk;
    logic        nRst;
    logic        mem_read;
    logic        mem_write;
    logic        byte_access;
    logic [31:0] address;
    logic [31:0] store_data;
    logic        bus_ack;
    logic [31:0] bus_rdata;
    logic [31:0] bus_addr;
    logic [31:0] bus_wdata;
    logic [3:0]  bus_sel;
    logic        bus_read;
    logic        bus_write;
    logic [31:0] memory_value;
    logic        mem_busy;
    logic        misaligned;
    logic        bus_timeout;

    data_memory_handler #(.TIMEOUT_CYCLES(T)) dut (
        .clk         (clk),
        .nRst        (nRst),
        .mem_read    (mem_read),
        .mem_write   (mem_write),
        .byte_access (byte_access),
        .address     (address),
        .store_data  (store_data),
        .bus_ack     (bus_ack),
        .bus_rdata   (bus_rdata),
        .bus_addr    (bus_addr),
        .bus_wdata   (bus_wdata),
        .bus_sel     (bus_sel),
        .bus_read    (bus_read),
        .bus_write   (bus_write),
        .memory_value(memory_value),
        .mem_busy    (mem_busy),
        .misaligned  (misaligned),
        .bus_timeout (bus_timeout)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic        rd;
        logic        wr;
        logic        byt;
        logic [31:0] addr;
        logic [31:0] sdata;
        int          delay;     // REQ cycles before ack; >= T means never
        logic [31:0] rdata;
        logic [31:0] e_addr;
        logic [31:0] e_wdata;
        logic [3:0]  e_sel;
        int          e_strobes; // cycles the strobe is high
        logic        e_mis;
        logic        e_to;
        logic [31:0] e_mem;     // memory_value in DONE
    } vec_t;

    int          passed = 0;
    int          total  = 0;
    logic [31:0] model_mem;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act === exp) passed++;
        else $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Transaction-level reference: outcome derived directly from the access rules.
    function automatic vec_t model(input logic rd, input logic wr, input logic byt,
                                   input logic [31:0] addr, input logic [31:0] sdata,
                                   input int delay, input logic [31:0] rdata,
                                   input logic [31:0] cur_mem);
        vec_t v;
        int   off;
        off         = int'(addr % 4);
        v.rd        = rd;
        v.wr        = wr;
        v.byt       = byt;
        v.addr      = addr;
        v.sdata     = sdata;
        v.delay     = delay;
        v.rdata     = rdata;
        v.e_mis     = !byt && (off != 0);
        v.e_addr    = addr - 32'(off);
        v.e_sel     = byt ? 4'(1 << off) : 4'hF;
        v.e_wdata   = byt ? (32'(sdata[7:0]) * 32'h01010101) : sdata;
        v.e_to      = !v.e_mis && (delay >= T);
        v.e_strobes = v.e_mis ? 0 : ((delay < T) ? delay + 1 : T);
        if (v.e_mis || wr)  v.e_mem = cur_mem;
        else if (v.e_to)    v.e_mem = 32'd0;
        else if (byt)       v.e_mem = rdata / (32'd1 << (8 * off));
        else                v.e_mem = rdata;
        return v;
    endfunction

    task automatic apply(input vec_t v);
        mem_read    = v.rd;
        mem_write   = v.wr;
        byte_access = v.byt;
        address     = v.addr;
        store_data  = v.sdata;
        bus_ack     = 1'b0;
        bus_rdata   = $urandom;
        #1;
        chk("busy_first", 32'(mem_busy), 32'd1);
        chk("strobe_idle", 32'({bus_read, bus_write}), 32'd0);
        @(posedge clk);
        #1;
        for (int k = 0; k < v.e_strobes; k++) begin
            chk("strobe_req", 32'({bus_read, bus_write}), 32'({v.rd & ~v.wr, v.wr}));
            chk("bus_addr", bus_addr, v.e_addr);
            chk("bus_sel", 32'(bus_sel), 32'(v.e_sel));
            chk("bus_wdata", bus_wdata, v.e_wdata);
            chk("busy_req", 32'(mem_busy), 32'd1);
            chk("mem_hold_req", memory_value, model_mem);
            bus_ack   = (k == v.delay);
            bus_rdata = bus_ack ? v.rdata : $urandom;
            step();
            bus_ack = 1'b0;
        end
        chk("busy_done", 32'(mem_busy), 32'd0);
        chk("strobe_done", 32'({bus_read, bus_write}), 32'd0);
        chk("misaligned", 32'(misaligned), 32'(v.e_mis));
        chk("bus_timeout", 32'(bus_timeout), 32'(v.e_to));
        chk("memory_value", memory_value, v.e_mem);
        model_mem   = v.e_mem;
        mem_read    = 1'b0;
        mem_write   = 1'b0;
        bus_ack     = 1'($urandom % 2);
        bus_rdata   = $urandom;
        step();
        chk("flags_idle", 32'({misaligned, bus_timeout, mem_busy}), 32'd0);
        chk("mem_hold_idle", memory_value, model_mem);
        bus_ack = 1'b0;
    endtask

    vec_t tbl[10];

    initial begin
        //          rd    wr    byt   addr          sdata         dly rdata         e_addr        e_wdata       e_sel  str mis   to    e_mem
        tbl[0] = '{1'b1, 1'b0, 1'b0, 32'h0000_0100, 32'h0,        0, 32'hDEADBEEF, 32'h0000_0100, 32'h0,        4'hF, 1, 1'b0, 1'b0, 32'hDEADBEEF};
        tbl[1] = '{1'b1, 1'b0, 1'b1, 32'h0000_0203, 32'h0,        0, 32'h11223344, 32'h0000_0200, 32'h0,        4'h8, 1, 1'b0, 1'b0, 32'h00000011};
        tbl[2] = '{1'b0, 1'b1, 1'b1, 32'h0000_0302, 32'hABCD12EF, 3, 32'h0,        32'h0000_0300, 32'hEFEFEFEF, 4'h4, 4, 1'b0, 1'b0, 32'h00000011};
        tbl[3] = '{1'b1, 1'b0, 1'b0, 32'h0000_0102, 32'h0,        0, 32'h0,        32'h0,         32'h0,        4'h0, 0, 1'b1, 1'b0, 32'h00000011};
        tbl[4] = '{1'b1, 1'b0, 1'b0, 32'h0000_0400, 32'h0,       99, 32'h0,        32'h0000_0400, 32'h0,        4'hF, 4, 1'b0, 1'b1, 32'h00000000};
        tbl[5] = '{1'b1, 1'b1, 1'b0, 32'h0000_0500, 32'h12345678, 1, 32'h55555555, 32'h0000_0500, 32'h12345678, 4'hF, 2, 1'b0, 1'b0, 32'h00000000};
        tbl[6] = '{1'b1, 1'b0, 1'b1, 32'h0000_0501, 32'h0,        2, 32'hA1B2C3D4, 32'h0000_0500, 32'h0,        4'h2, 3, 1'b0, 1'b0, 32'h00A1B2C3};
        tbl[7] = '{1'b0, 1'b1, 1'b1, 32'h0000_0600, 32'h0000005A,99, 32'h0,        32'h0000_0600, 32'h5A5A5A5A, 4'h1, 4, 1'b0, 1'b1, 32'h00A1B2C3};
        tbl[8] = '{1'b0, 1'b1, 1'b0, 32'h0000_0703, 32'h77777777, 0, 32'h0,        32'h0,         32'h0,        4'h0, 0, 1'b1, 1'b0, 32'h00A1B2C3};
        tbl[9] = '{1'b1, 1'b0, 1'b0, 32'h0000_0800, 32'h0,        3, 32'hCAFEF00D, 32'h0000_0800, 32'h0,        4'hF, 4, 1'b0, 1'b0, 32'hCAFEF00D};

        nRst        = 1'b0;
        mem_read    = 1'b0;
        mem_write   = 1'b0;
        byte_access = 1'b0;
        address     = 32'd0;
        store_data  = 32'd0;
        bus_ack     = 1'b0;
        bus_rdata   = 32'd0;
        model_mem   = 32'd0;
        step();
        step();
        chk("rst_strobes", 32'({bus_read, bus_write, mem_busy, misaligned, bus_timeout}), 32'd0);
        chk("rst_bus_addr", bus_addr, 32'd0);
        chk("rst_bus_wdata", bus_wdata, 32'd0);
        chk("rst_bus_sel", 32'(bus_sel), 32'd0);
        chk("rst_memory_value", memory_value, 32'd0);
        nRst = 1'b1;
        step();

        for (int i = 0; i < 10; i++) apply(tbl[i]);

        for (int i = 0; i < 40; i++) begin
            logic rd, wr;
            int   sel_rw;
            sel_rw = int'($urandom_range(0, 2));
            rd = (sel_rw != 1);
            wr = (sel_rw != 0);
            apply(model(rd, wr, 1'($urandom % 2), $urandom, $urandom,
                        int'($urandom_range(0, T + 1)), $urandom, model_mem));
            for (int g = int'($urandom_range(0, 2)); g > 0; g--) begin
                bus_ack   = 1'($urandom % 2);
                bus_rdata = $urandom;
                step();
                chk("idle_gap", {mem_busy, memory_value[30:0]}, {1'b0, model_mem[30:0]});
            end
            bus_ack = 1'b0;
        end

        // Asynchronous reset while a load is waiting for its ack.
        mem_read    = 1'b1;
        mem_write   = 1'b0;
        byte_access = 1'b0;
        address     = 32'h0000_0900;
        step();
        chk("pre_rst_read", 32'(bus_read), 32'd1);
        nRst = 1'b0;
        #1;
        chk("async_rst_read", 32'(bus_read), 32'd0);
        chk("async_rst_busy", 32'(mem_busy), 32'd0);
        chk("async_rst_mem", memory_value, 32'd0);
        model_mem = 32'd0;
        mem_read  = 1'b0;
        step();
        nRst = 1'b1;
        step();
        chk("post_rst_idle", 32'({bus_read, bus_write, mem_busy}), 32'd0);
        apply(model(1'b1, 1'b0, 1'b1, 32'h0000_0A02, 32'h0, 0, 32'h99887766, model_mem));

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
